// File: rtl/hazard_scoreboard.sv
// ID-stage hazard controller: pending-destination scoreboard for long-latency
// ops, plus load-use / RAW / WAW / structural stall generation.
module hazard_scoreboard #(
   parameter int unsigned MAX_LONG = 4,
   parameter int unsigned CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             IF_ID_Valid,
   input  logic [4:0]       IF_ID_RsAddr,
   input  logic [4:0]       IF_ID_RtAddr,
   input  logic             IF_ID_UseRs,
   input  logic             IF_ID_UseRt,
   input  logic             IF_ID_RegWr,
   input  logic [4:0]       IF_ID_RegWrAddr,
   input  logic             IF_ID_Long,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_RegWrAddr,
   input  logic             LongOp_Done,
   input  logic [4:0]       LongOp_DoneAddr,
   output logic             Stall_PC,
   output logic             Stall_IF_ID,
   output logic             Flush_ID_EX,
   output logic [31:0]      PendingMask,
   output logic [CNT_W-1:0] OutstandingCnt,
   output logic [31:0]      StallCycles,
   output logic             Err
);

   localparam int unsigned NREG = 32;

   logic [NREG-1:0]  pending_q, pending_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      stall_cycles_q, stall_cycles_d;
   logic             err_q, err_d;

   logic load_use_c, raw_c, waw_c, struct_c, stall_c, accept_c, dec_c;

   // Hazard detection from registered scoreboard and current ID/EX inputs
   always_comb begin
      load_use_c = 1'b0;
      raw_c      = 1'b0;
      waw_c      = 1'b0;
      struct_c   = 1'b0;
      if (ID_EX_MemRead && (ID_EX_RegWrAddr != 5'd0)) begin
         load_use_c = (IF_ID_UseRs && (IF_ID_RsAddr == ID_EX_RegWrAddr)) ||
                      (IF_ID_UseRt && (IF_ID_RtAddr == ID_EX_RegWrAddr));
      end
      raw_c    = (IF_ID_UseRs && pending_q[IF_ID_RsAddr]) ||
                 (IF_ID_UseRt && pending_q[IF_ID_RtAddr]);
      waw_c    = IF_ID_RegWr && pending_q[IF_ID_RegWrAddr];
      struct_c = IF_ID_Long && (cnt_q == CNT_W'(MAX_LONG));
      stall_c  = IF_ID_Valid && (load_use_c || raw_c || waw_c || struct_c);
      accept_c = IF_ID_Valid && IF_ID_Long && !stall_c;
   end

   // Next-state: issue sets, completion clears; protocol errors are sticky
   always_comb begin
      pending_d      = pending_q;
      cnt_d          = cnt_q;
      stall_cycles_d = stall_cycles_q;
      err_d          = err_q;
      dec_c          = LongOp_Done && (cnt_q != '0);

      if (LongOp_Done) begin
         if (cnt_q == '0) begin
            err_d = 1'b1;
         end
         if (LongOp_DoneAddr != 5'd0) begin
            if (pending_q[LongOp_DoneAddr]) begin
               pending_d[LongOp_DoneAddr] = 1'b0;
            end else begin
               err_d = 1'b1;
            end
         end
      end

      // Same-address set+clear is impossible: WAW blocks such an issue
      if (accept_c && IF_ID_RegWr && (IF_ID_RegWrAddr != 5'd0)) begin
         pending_d[IF_ID_RegWrAddr] = 1'b1;
      end
      pending_d[0] = 1'b0;

      cnt_d = cnt_q + CNT_W'(accept_c) - CNT_W'(dec_c);

      if (stall_c && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
   end

   // State registers; reset discards all in-flight tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q      <= '0;
         cnt_q          <= '0;
         stall_cycles_q <= '0;
         err_q          <= 1'b0;
      end else begin
         pending_q      <= pending_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
         err_q          <= err_d;
      end
   end

   assign Stall_PC       = stall_c;
   assign Stall_IF_ID    = stall_c;
   assign Flush_ID_EX    = stall_c;
   assign PendingMask    = pending_q;
   assign OutstandingCnt = cnt_q;
   assign StallCycles    = stall_cycles_q;
   assign Err            = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: the driver pushes expected per-cycle
// observations, the monitor pops and compares on the falling edge.
module tb_hazard_scoreboard;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             IF_ID_Valid, IF_ID_UseRs, IF_ID_UseRt, IF_ID_RegWr, IF_ID_Long;
   logic [4:0]       IF_ID_RsAddr, IF_ID_RtAddr, IF_ID_RegWrAddr;
   logic             ID_EX_MemRead;
   logic [4:0]       ID_EX_RegWrAddr;
   logic             LongOp_Done;
   logic [4:0]       LongOp_DoneAddr;
   logic             Stall_PC, Stall_IF_ID, Flush_ID_EX, Err;
   logic [31:0]      PendingMask, StallCycles;
   logic [CNT_W-1:0] OutstandingCnt;

   hazard_scoreboard #(.MAX_LONG(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_Valid(IF_ID_Valid), .IF_ID_RsAddr(IF_ID_RsAddr), .IF_ID_RtAddr(IF_ID_RtAddr),
      .IF_ID_UseRs(IF_ID_UseRs), .IF_ID_UseRt(IF_ID_UseRt), .IF_ID_RegWr(IF_ID_RegWr),
      .IF_ID_RegWrAddr(IF_ID_RegWrAddr), .IF_ID_Long(IF_ID_Long),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrAddr(ID_EX_RegWrAddr),
      .LongOp_Done(LongOp_Done), .LongOp_DoneAddr(LongOp_DoneAddr),
      .Stall_PC(Stall_PC), .Stall_IF_ID(Stall_IF_ID), .Flush_ID_EX(Flush_ID_EX),
      .PendingMask(PendingMask), .OutstandingCnt(OutstandingCnt),
      .StallCycles(StallCycles), .Err(Err)
   );

   always #5 clk = ~clk;

   // chk bits: 0 stall, 1 pending, 2 count, 3 stall-cycles, 4 err
   typedef struct {
      string       name;
      logic [4:0]  chk;
      logic        stall;
      logic [31:0] pend;
      logic [3:0]  cnt;
      logic [31:0] sc;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
      end
   endtask

   // Monitor: one expected record per cycle, sampled away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.chk[0]) begin
               cmp({e.name, ".Stall_PC"},    32'(Stall_PC),    32'(e.stall));
               cmp({e.name, ".Stall_IF_ID"}, 32'(Stall_IF_ID), 32'(e.stall));
               cmp({e.name, ".Flush_ID_EX"}, 32'(Flush_ID_EX), 32'(e.stall));
            end
            if (e.chk[1]) cmp({e.name, ".PendingMask"},    PendingMask,         e.pend);
            if (e.chk[2]) cmp({e.name, ".OutstandingCnt"}, 32'(OutstandingCnt), 32'(e.cnt));
            if (e.chk[3]) cmp({e.name, ".StallCycles"},    StallCycles,         e.sc);
            if (e.chk[4]) cmp({e.name, ".Err"},            32'(Err),            32'(e.err));
         end
      end
   end

   task automatic idle();
      IF_ID_Valid = 0; IF_ID_UseRs = 0; IF_ID_UseRt = 0; IF_ID_RegWr = 0; IF_ID_Long = 0;
      IF_ID_RsAddr = 0; IF_ID_RtAddr = 0; IF_ID_RegWrAddr = 0;
      ID_EX_MemRead = 0; ID_EX_RegWrAddr = 0; LongOp_Done = 0; LongOp_DoneAddr = 0;
   endtask

   // Push expectation for the current cycle's inputs, then advance to next cycle
   task automatic expect_cyc(input string nm, input logic [4:0] chk, input logic stall,
                             input logic [31:0] pend, input logic [3:0] cnt,
                             input logic [31:0] sc, input logic err);
      exp_t e;
      e.name = nm; e.chk = chk; e.stall = stall; e.pend = pend;
      e.cnt = cnt; e.sc = sc; e.err = err;
      q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic long_op(input logic [4:0] dst);
      idle();
      IF_ID_Valid = 1; IF_ID_Long = 1; IF_ID_RegWr = 1; IF_ID_RegWrAddr = dst;
   endtask

   task automatic done(input logic [4:0] a);
      LongOp_Done = 1; LongOp_DoneAddr = a;
   endtask

   localparam logic [4:0] ALL = 5'b11111;

   initial begin
      rst_n = 0;
      idle();
      @(posedge clk); #1;
      expect_cyc("reset", ALL, 0, 32'h0, 0, 0, 0);

      rst_n = 1;
      // load-use on rs
      idle(); IF_ID_Valid = 1; IF_ID_UseRs = 1; IF_ID_RsAddr = 8;
      ID_EX_MemRead = 1; ID_EX_RegWrAddr = 8;
      expect_cyc("lu_hit", ALL, 1, 32'h0, 0, 0, 0);
      ID_EX_RegWrAddr = 0;
      expect_cyc("lu_r0", ALL, 0, 32'h0, 0, 1, 0);
      ID_EX_MemRead = 0; ID_EX_RegWrAddr = 8;
      expect_cyc("lu_noload", ALL, 0, 32'h0, 0, 1, 0);

      // long issue then RAW on rt
      long_op(5);
      expect_cyc("div_issue", ALL, 0, 32'h0, 0, 1, 0);
      idle(); IF_ID_Valid = 1; IF_ID_UseRt = 1; IF_ID_RtAddr = 5;
      expect_cyc("raw1", ALL, 1, 32'h20, 1, 1, 0);
      expect_cyc("raw2", ALL, 1, 32'h20, 1, 2, 0);
      done(5);
      expect_cyc("raw_done_same", ALL, 1, 32'h20, 1, 3, 0);
      LongOp_Done = 0; LongOp_DoneAddr = 0;
      expect_cyc("raw_release", ALL, 0, 32'h0, 0, 4, 0);

      // structural: fill to MAX_LONG
      long_op(1); expect_cyc("fill1", ALL, 0, 32'h0,  0, 4, 0);
      long_op(2); expect_cyc("fill2", ALL, 0, 32'h2,  1, 4, 0);
      long_op(3); expect_cyc("fill3", ALL, 0, 32'h6,  2, 4, 0);
      long_op(4); expect_cyc("fill4", ALL, 0, 32'hE,  3, 4, 0);
      long_op(6); expect_cyc("struct1", ALL, 1, 32'h1E, 4, 4, 0);
      done(2);    expect_cyc("struct_done", ALL, 1, 32'h1E, 4, 5, 0);
      long_op(6); expect_cyc("struct_accept", ALL, 0, 32'h1A, 3, 6, 0);

      // free a slot, then simultaneous accept(9) + done(3)
      idle(); done(1);
      expect_cyc("free1", ALL, 0, 32'h5A, 4, 6, 0);
      long_op(9); done(3);
      expect_cyc("simul", ALL, 0, 32'h58, 3, 6, 0);
      idle();
      expect_cyc("simul_after", ALL, 0, 32'h250, 3, 6, 0);

      // drain
      done(4); expect_cyc("drain4", 5'b00110, 0, 32'h250, 3, 0, 0);
      done(6); expect_cyc("drain6", 5'b00110, 0, 32'h240, 2, 0, 0);
      done(9); expect_cyc("drain9", 5'b00110, 0, 32'h200, 1, 0, 0);

      // error: completion with nothing outstanding
      done(7); expect_cyc("err_pre", ALL, 0, 32'h0, 0, 6, 0);
      idle();  expect_cyc("err_set", ALL, 0, 32'h0, 0, 6, 1);

      // long op to r0 counts but sets no pending bit
      long_op(0); expect_cyc("r0_issue", ALL, 0, 32'h0, 0, 6, 1);
      idle(); done(0);
      expect_cyc("r0_inflight", ALL, 0, 32'h0, 1, 6, 1);
      idle();
      expect_cyc("r0_done", ALL, 0, 32'h0, 0, 6, 1);

      // async reset mid-operation
      long_op(10); expect_cyc("rst_fill1", 5'b00110, 0, 32'h0,   0, 0, 0);
      long_op(11); expect_cyc("rst_fill2", 5'b00110, 0, 32'h400, 1, 0, 0);
      long_op(12); expect_cyc("rst_fill3", 5'b00110, 0, 32'hC00, 2, 0, 0);
      idle(); IF_ID_Valid = 1; IF_ID_UseRs = 1; IF_ID_RsAddr = 10;
      expect_cyc("rst_raw", ALL, 1, 32'h1C00, 3, 6, 1);
      rst_n = 0;
      expect_cyc("rst_async", ALL, 0, 32'h0, 0, 0, 0);
      rst_n = 1; idle();
      expect_cyc("rst_release", ALL, 0, 32'h0, 0, 0, 0);

      // bounded drain of the scoreboard queue
      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: %0d records left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
